fft_sdf_stage: RTL and testbench

- Parametrised radix-2 DIF single-delay-feedback FFT stage for the lane-parallel streaming FFT datapath; successor to the fixed stage-1 block.
- Each lane performs butterfly, delay line, output mux, externally supplied twiddle multiply, rounding, optional /2 scaling and saturation.
- Adds valid gaps, a ready handshake, frame resync and an explicit flush/drain FSM.
- Stages chain output to input, with DATA growing by 2 per stage.

---
 rtl/fft_sdf_stage_if.sv | 37 +++
 rtl/fft_sdf_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_fft_sdf_stage.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_sdf_stage_if.sv
// Streaming port bundle for one radix-2 SDF FFT stage.
//   valid_in/ready_in/sync_in/flush : input beat handshake and control
//   din_re/din_im                   : LANES x DATA input samples
//   tw_addr, tw_re/tw_im            : twiddle request index and returned twiddles
//   valid_out, dout_re/dout_im      : LANES x (DATA+2) output samples
// The stage uses the slave modport; the producer/twiddle source uses master.
interface fft_sdf_stage_if #(
  parameter int DATA  = 10,
  parameter int LANES = 16,
  parameter int DEPTH = 8,
  parameter int TW_W  = 10
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                        valid_in;
  logic                        ready_in;
  logic                        sync_in;
  logic                        flush;
  logic [LANES-1:0][DATA-1:0]  din_re;
  logic [LANES-1:0][DATA-1:0]  din_im;
  logic [AW-1:0]               tw_addr;
  logic [LANES-1:0][TW_W-1:0]  tw_re;
  logic [LANES-1:0][TW_W-1:0]  tw_im;
  logic                        valid_out;
  logic [LANES-1:0][DATA+1:0]  dout_re;
  logic [LANES-1:0][DATA+1:0]  dout_im;

  modport master (
    output valid_in, sync_in, flush, din_re, din_im, tw_re, tw_im,
    input  ready_in, tw_addr, valid_out, dout_re, dout_im
  );

  modport slave (
    input  valid_in, sync_in, flush, din_re, din_im, tw_re, tw_im,
    output ready_in, tw_addr, valid_out, dout_re, dout_im
  );
endinterface

// File: rtl/fft_sdf_stage.sv
// Radix-2 DIF single-delay-feedback FFT stage, LANES complex samples per beat.
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : fft_sdf_stage_if.slave (handshake, samples, twiddle request/return)
// Pipeline: S0 delay-line access (acceptance edge), S1 butterfly/mux and
// tw_addr, S2 twiddle multiply, S3 round/scale/saturate to the outputs.
//
// state | meaning
// RUN   | accepting beats, ready_in=1
// DRAIN | ready_in=0, walk slots 0..DEPTH-1 emitting pending differences
module fft_sdf_stage #(
  parameter int DATA  = 10,
  parameter int LANES = 16,
  parameter int DEPTH = 8,
  parameter int TW_W  = 10,
  parameter int SCALE = 0
) (
  input  logic           clk,
  input  logic           rstn,
  fft_sdf_stage_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(2*DEPTH);
  localparam int VW = DATA + 1;
  localparam int PW = VW + TW_W + 1;
  localparam int OW = DATA + 2;
  localparam int SH = TW_W - 2 + SCALE;
  localparam logic signed [TW_W-1:0] ONE  = TW_W'(1) << (TW_W-2);
  localparam logic signed [PW:0]     HALF = ({{PW{1'b0}}, 1'b1} << SH) >> 1;
  localparam logic signed [PW:0]     SAT_MAX = {{(PW-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [PW:0]     SAT_MIN = {{(PW-OW+2){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic {RUN, DRAIN} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    w_ready, w_drain, w_acc, w_phb;
  logic [CW-1:0]           r_cnt, w_cnt_eff, w_cnt_nxt;
  logic [AW-1:0]           r_didx, w_k, w_rk;
  logic [DEPTH-1:0]        r_pend;
  logic [LANES-1:0][VW-1:0] r_mem_re [DEPTH];
  logic [LANES-1:0][VW-1:0] r_mem_im [DEPTH];
  logic [LANES-1:0][VW-1:0] w_a_re, w_a_im, w_dx_re, w_dx_im, w_wr_re, w_wr_im;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_drain     = 1'b0;
    case (r_state)
      RUN: begin
        w_ready = 1'b1;
        // A beat on valid_in always takes priority over a flush request.
        if (bus.flush && !bus.valid_in && r_cnt == '0 && r_pend != '0)
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_drain = 1'b1;
        if (r_didx == AW'(DEPTH-1)) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign bus.ready_in = w_ready;

  // ---------------- beat counter / slot decode ----------------
  assign w_acc     = bus.valid_in & w_ready;
  assign w_cnt_eff = bus.sync_in ? '0 : r_cnt;
  assign w_phb     = (w_cnt_eff >= CW'(DEPTH));
  assign w_k       = w_phb ? AW'(w_cnt_eff - CW'(DEPTH)) : AW'(w_cnt_eff);
  assign w_cnt_nxt = (w_cnt_eff == CW'(2*DEPTH-1)) ? '0 : w_cnt_eff + 1'b1;
  assign w_rk      = w_drain ? r_didx : w_k;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt  <= '0;
      r_didx <= '0;
      r_pend <= '0;
    end else if (w_drain) begin
      r_pend[r_didx] <= 1'b0;
      if (r_didx == AW'(DEPTH-1)) begin
        r_didx <= '0;
        r_cnt  <= '0;
      end else begin
        r_didx <= r_didx + 1'b1;
      end
    end else if (w_acc) begin
      r_pend[w_k] <= w_phb;
      r_cnt       <= w_cnt_nxt;
    end
  end

  // ---------------- S0: delay line ----------------
  // Phase A stores the sign-extended input; phase B stores the difference a-b.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_a_re[l]  = r_mem_re[w_rk][l];
      w_a_im[l]  = r_mem_im[w_rk][l];
      w_dx_re[l] = {bus.din_re[l][DATA-1], bus.din_re[l]};
      w_dx_im[l] = {bus.din_im[l][DATA-1], bus.din_im[l]};
      w_wr_re[l] = w_phb ? (w_a_re[l] - w_dx_re[l]) : w_dx_re[l];
      w_wr_im[l] = w_phb ? (w_a_im[l] - w_dx_im[l]) : w_dx_im[l];
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_mem_re[w_k] <= w_wr_re;
      r_mem_im[w_k] <= w_wr_im;
    end
  end

  logic                     r0_vld, r0_rd, r0_phb;
  logic [AW-1:0]            r0_k;
  logic [LANES-1:0][VW-1:0] r0_a_re, r0_a_im, r0_b_re, r0_b_im;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r0_vld  <= 1'b0;
      r0_rd   <= 1'b0;
      r0_phb  <= 1'b0;
      r0_k    <= '0;
      r0_a_re <= '0;
      r0_a_im <= '0;
      r0_b_re <= '0;
      r0_b_im <= '0;
    end else begin
      r0_vld  <= w_drain ? r_pend[w_rk] : (w_acc & (w_phb | r_pend[w_rk]));
      r0_rd   <= w_drain | (w_acc & ~w_phb);
      r0_phb  <= ~w_drain & w_acc & w_phb;
      r0_k    <= w_rk;
      r0_a_re <= w_a_re;
      r0_a_im <= w_a_im;
      r0_b_re <= w_dx_re;
      r0_b_im <= w_dx_im;
    end
  end

  // ---------------- S1: butterfly sum / mux, twiddle request ----------------
  logic                     r1_vld, r1_byp;
  logic [LANES-1:0][VW-1:0] r1_v_re, r1_v_im;
  logic [AW-1:0]            r_tw_addr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r1_vld    <= 1'b0;
      r1_byp    <= 1'b0;
      r1_v_re   <= '0;
      r1_v_im   <= '0;
      r_tw_addr <= '0;
    end else begin
      r1_vld <= r0_vld;
      r1_byp <= r0_phb;
      for (int l = 0; l < LANES; l++) begin
        r1_v_re[l] <= r0_phb ? (r0_a_re[l] + r0_b_re[l]) : r0_a_re[l];
        r1_v_im[l] <= r0_phb ? (r0_a_im[l] + r0_b_im[l]) : r0_a_im[l];
      end
      if (r0_rd) r_tw_addr <= r0_k;
    end
  end

  assign bus.tw_addr = r_tw_addr;

  // ---------------- S2: complex multiply ----------------
  // Sums are forced through the multiplier as exact x1.0 so both paths share
  // the same rounding/scaling stage.
  logic signed [PW-1:0] w_vr [LANES], w_vi [LANES], w_tr [LANES], w_ti [LANES];
  logic signed [PW-1:0] r2_re [LANES], r2_im [LANES];
  logic                 r2_vld;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_vr[l] = PW'($signed(r1_v_re[l]));
      w_vi[l] = PW'($signed(r1_v_im[l]));
      w_tr[l] = r1_byp ? PW'(ONE) : PW'($signed(bus.tw_re[l]));
      w_ti[l] = r1_byp ? '0       : PW'($signed(bus.tw_im[l]));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r2_vld <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        r2_re[l] <= '0;
        r2_im[l] <= '0;
      end
    end else begin
      r2_vld <= r1_vld;
      for (int l = 0; l < LANES; l++) begin
        r2_re[l] <= w_vr[l] * w_tr[l] - w_vi[l] * w_ti[l];
        r2_im[l] <= w_vr[l] * w_ti[l] + w_vi[l] * w_tr[l];
      end
    end
  end

  // ---------------- S3: round half-up, shift, saturate ----------------
  logic signed [PW:0]       w_sum_re [LANES], w_sum_im [LANES];
  logic signed [PW:0]       w_sh_re [LANES], w_sh_im [LANES];
  logic [LANES-1:0][OW-1:0] w_o_re, w_o_im, r_dout_re, r_dout_im;
  logic                     r_vout;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_sum_re[l] = {r2_re[l][PW-1], r2_re[l]} + HALF;
      w_sum_im[l] = {r2_im[l][PW-1], r2_im[l]} + HALF;
      w_sh_re[l]  = w_sum_re[l] >>> SH;
      w_sh_im[l]  = w_sum_im[l] >>> SH;
      if (w_sh_re[l] > SAT_MAX)      w_o_re[l] = SAT_MAX[OW-1:0];
      else if (w_sh_re[l] < SAT_MIN) w_o_re[l] = SAT_MIN[OW-1:0];
      else                           w_o_re[l] = w_sh_re[l][OW-1:0];
      if (w_sh_im[l] > SAT_MAX)      w_o_im[l] = SAT_MAX[OW-1:0];
      else if (w_sh_im[l] < SAT_MIN) w_o_im[l] = SAT_MIN[OW-1:0];
      else                           w_o_im[l] = w_sh_im[l][OW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vout    <= 1'b0;
      r_dout_re <= '0;
      r_dout_im <= '0;
    end else begin
      r_vout    <= r2_vld;
      r_dout_re <= w_o_re;
      r_dout_im <= w_o_im;
    end
  end

  assign bus.valid_out = r_vout;
  assign bus.dout_re   = r_dout_re;
  assign bus.dout_im   = r_dout_im;
endmodule

// File: tb/tb_fft_sdf_stage.sv
// Directed bench for fft_sdf_stage (DATA=10, LANES=2, DEPTH=4, TW_W=10).
// dut0 is SCALE=0, dut1 is SCALE=1 fed identical stimulus.
module tb_fft_sdf_stage;
  localparam int DATA = 10, LANES = 2, DEPTH = 4, TW_W = 10, NV = 44;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fft_sdf_stage_if #(.DATA(DATA), .LANES(LANES), .DEPTH(DEPTH), .TW_W(TW_W)) if0 ();
  fft_sdf_stage_if #(.DATA(DATA), .LANES(LANES), .DEPTH(DEPTH), .TW_W(TW_W)) if1 ();

  assign if1.valid_in = if0.valid_in;
  assign if1.sync_in  = if0.sync_in;
  assign if1.flush    = if0.flush;
  assign if1.din_re   = if0.din_re;
  assign if1.din_im   = if0.din_im;
  assign if1.tw_re    = if0.tw_re;
  assign if1.tw_im    = if0.tw_im;

  fft_sdf_stage #(.DATA(DATA), .LANES(LANES), .DEPTH(DEPTH), .TW_W(TW_W), .SCALE(0))
    dut0 (.clk(clk), .rstn(rstn), .bus(if0.slave));
  fft_sdf_stage #(.DATA(DATA), .LANES(LANES), .DEPTH(DEPTH), .TW_W(TW_W), .SCALE(1))
    dut1 (.clk(clk), .rstn(rstn), .bus(if1.slave));

  typedef struct {
    bit vin, syn, fl;
    int d0r, d0i, d1r, d1i;
    int twr, twi;
    bit evo, ery;
    int e0r, e0i, e1r, e1i, es0;
    int eta;
  } vec_t;

  vec_t tv [NV];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit vin, input bit syn, input bit fl,
                       input int d0r, input int d0i, input int d1r, input int d1i,
                       input int twr, input int twi);
    if0.valid_in  = vin;
    if0.sync_in   = syn;
    if0.flush     = fl;
    if0.din_re[0] = DATA'(d0r);
    if0.din_im[0] = DATA'(d0i);
    if0.din_re[1] = DATA'(d1r);
    if0.din_im[1] = DATA'(d1i);
    for (int l = 0; l < LANES; l++) begin
      if0.tw_re[l] = TW_W'(twr);
      if0.tw_im[l] = TW_W'(twi);
    end
  endtask

  task automatic setb(input int i, input int a0r, input int a0i, input int a1r, input int a1i);
    tv[i].vin = 1'b1;
    tv[i].d0r = a0r; tv[i].d0i = a0i; tv[i].d1r = a1r; tv[i].d1i = a1i;
  endtask

  task automatic seto(input int i, input int e0r, input int e0i, input int e1r,
                      input int e1i, input int es0);
    tv[i].evo = 1'b1;
    tv[i].e0r = e0r; tv[i].e0i = e0i; tv[i].e1r = e1r; tv[i].e1i = e1i; tv[i].es0 = es0;
  endtask

  function automatic int sre(input logic [DATA+1:0] x);
    return int'($signed(x));
  endfunction

  int q0[$], q1[$];
  int rdy_bad;
  bit seen;
  int exp0[8] = '{120, 120, 120, 120, 80, 80, 80, 80};
  int exp1[8] = '{-40, -40, -40, -40, -60, -60, -60, -60};

  initial begin
    // ---------- vector table ----------
    for (int i = 0; i < NV; i++) begin
      tv[i] = '{default: 0};
      tv[i].ery = 1'b1;
      tv[i].eta = -1;
      tv[i].twr = 256;
      if (i >= 18 && i <= 21) begin tv[i].twr = 0;   tv[i].twi = -256; end
      if (i >= 22 && i <= 30) begin tv[i].twr = 128; tv[i].twi = 0;    end
    end
    // frame 1: a = 100 | -50+30j, b = 20 | 10-6j
    for (int i = 0;  i < 4;  i++) setb(i, 100, 0, -50, 30);
    for (int i = 4;  i < 8;  i++) setb(i, 20, 0, 10, -6);
    tv[0].syn = 1'b1;
    // frame 2: a = 50 | 10+5j, b = -30 | 4+1j
    for (int i = 8;  i < 12; i++) setb(i, 50, 0, 10, 5);
    for (int i = 12; i < 16; i++) setb(i, -30, 0, 4, 1);
    // frame 3: a = 5 | -5, b = 2 | -2
    for (int i = 16; i < 20; i++) setb(i, 5, 0, -5, 0);
    for (int i = 20; i < 24; i++) setb(i, 2, 0, -2, 0);
    // flush after beat 7, then a second flush with nothing pending
    tv[24].fl = 1'b1;
    for (int i = 24; i < 28; i++) tv[i].ery = 1'b0;
    tv[29].fl = 1'b1;
    // resync: beats cnt 0..5, sync beat, three more beats
    for (int i = 31; i < 35; i++) setb(i, 30, 0, -30, 0);
    for (int i = 35; i < 37; i++) setb(i, 10, 0, -10, 0);
    for (int i = 37; i < 41; i++) setb(i, 0, 0, 0, 0);
    tv[37].syn = 1'b1;
    // expected outputs
    for (int i = 7;  i < 11; i++) seto(i, 120, 0, -40, 24, 60);
    for (int i = 11; i < 15; i++) seto(i, 80, 0, -60, 36, 40);
    for (int i = 15; i < 19; i++) seto(i, 20, 0, 14, 6, 10);
    for (int i = 19; i < 23; i++) seto(i, 0, -80, 4, -6, 0);
    for (int i = 23; i < 27; i++) seto(i, 7, 0, -7, 0, 4);
    for (int i = 28; i < 32; i++) seto(i, 2, 0, -1, 0, 1);
    for (int i = 38; i < 40; i++) seto(i, 40, 0, -40, 0, 20);
    for (int i = 40; i < 42; i++) seto(i, 20, 0, -20, 0, 10);
    for (int i = 9;  i < 13; i++) tv[i].eta = i - 9;
    for (int i = 17; i < 21; i++) tv[i].eta = i - 17;
    for (int i = 26; i < 30; i++) tv[i].eta = i - 26;
    tv[40].eta = 2;
    tv[41].eta = 3;

    // ---------- power-on reset ----------
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 256, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready_in", int'(if0.ready_in), 1);
    chk("reset valid_out", int'(if0.valid_out), 0);
    chk("reset dout_re0", sre(if0.dout_re[0]), 0);
    chk("reset tw_addr", int'(if0.tw_addr), 0);
    rstn = 1'b1;

    // ---------- table-driven section ----------
    for (int i = 0; i < NV; i++) begin
      drive(tv[i].vin, tv[i].syn, tv[i].fl, tv[i].d0r, tv[i].d0i, tv[i].d1r, tv[i].d1i,
            tv[i].twr, tv[i].twi);
      @(posedge clk);
      #1;
      chk($sformatf("r%0d valid_out", i), int'(if0.valid_out), int'(tv[i].evo));
      chk($sformatf("r%0d ready_in", i), int'(if0.ready_in), int'(tv[i].ery));
      chk($sformatf("r%0d scaled valid_out", i), int'(if1.valid_out), int'(tv[i].evo));
      chk($sformatf("r%0d scaled ready_in", i), int'(if1.ready_in), int'(tv[i].ery));
      if (tv[i].evo) begin
        chk($sformatf("r%0d lane0 re", i), sre(if0.dout_re[0]), tv[i].e0r);
        chk($sformatf("r%0d lane0 im", i), sre(if0.dout_im[0]), tv[i].e0i);
        chk($sformatf("r%0d lane1 re", i), sre(if0.dout_re[1]), tv[i].e1r);
        chk($sformatf("r%0d lane1 im", i), sre(if0.dout_im[1]), tv[i].e1i);
        chk($sformatf("r%0d scaled lane0 re", i), sre(if1.dout_re[0]), tv[i].es0);
      end
      if (tv[i].eta >= 0)
        chk($sformatf("r%0d tw_addr", i), int'(if0.tw_addr), tv[i].eta);
    end

    // ---------- reset asserted while an output beat is live ----------
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      drive(1, 0, 0, 10, 0, -10, 0, 256, 0);
      @(posedge clk);
      #1;
      if (if0.valid_out) seen = 1'b1;
    end
    chk("midrst live beat seen", int'(seen), 1);
    chk("midrst live beat lane0 re", sre(if0.dout_re[0]), 10);
    #2 rstn = 1'b0;
    #1;
    chk("midrst ready_in", int'(if0.ready_in), 1);
    chk("midrst valid_out", int'(if0.valid_out), 0);
    chk("midrst dout_re0", sre(if0.dout_re[0]), 0);
    chk("midrst dout_im1", sre(if0.dout_im[1]), 0);
    chk("midrst tw_addr", int'(if0.tw_addr), 0);
    chk("midrst scaled valid_out", int'(if1.valid_out), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 256, 0);
    @(negedge clk);
    rstn = 1'b1;

    // ---------- fresh frame with a gap after every beat ----------
    rdy_bad = 0;
    for (int b = 0; b < 24 + 8; b++) begin
      if (b < 24 && (b % 2) == 0) begin
        if (b < 8)       drive(1, 0, 0, 100, 0, -50, 30, 256, 0);
        else if (b < 16) drive(1, 0, 0, 20, 0, 10, -6, 256, 0);
        else             drive(1, 0, 0, 0, 0, 0, 0, 256, 0);
      end else begin
        drive(0, 0, 0, 0, 0, 0, 0, 256, 0);
      end
      @(posedge clk);
      #1;
      if (if0.valid_out) begin
        q0.push_back(sre(if0.dout_re[0]));
        q1.push_back(sre(if0.dout_re[1]));
      end
      if (!if0.ready_in) rdy_bad++;
    end
    chk("gaps output count", q0.size(), 8);
    chk("gaps ready_in drops", rdy_bad, 0);
    for (int i = 0; i < 8 && i < q0.size(); i++) begin
      chk($sformatf("gaps beat%0d lane0 re", i), q0[i], exp0[i]);
      chk($sformatf("gaps beat%0d lane1 re", i), q1[i], exp1[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
